// File: rtl/memory_bus_responder_if.sv
// Handshake bundle between a bus initiator and memory_bus_responder.
interface memory_bus_responder_if #(
    parameter int ADDRESS_SIZE = 16
);
    logic                    strobe;
    logic [ADDRESS_SIZE-1:0] address;
    logic [3:0]              writeEnable;
    logic [31:0]             dataWrite;
    logic [31:0]             dataRead;
    logic                    ready;
    logic                    error;

    modport master (
        output strobe, address, writeEnable, dataWrite,
        input  dataRead, ready, error
    );

    modport slave (
        input  strobe, address, writeEnable, dataWrite,
        output dataRead, ready, error
    );
endinterface

// File: rtl/memory_bus_responder.sv
// Single-port word memory behind a strobe/ready bus with programmable wait states,
// byte-lane writes and out-of-range error reporting.
module memory_bus_responder #(
    parameter int ADDRESS_SIZE = 16,
    parameter int MEM_WORDS    = 2048,
    parameter int WAIT_STATES  = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    memory_bus_responder_if.slave bus
);
    localparam int         MEM_AW    = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACCESS, ST_RESP} state_t;
    state_t state_reg, state_next;

    logic [ADDRESS_SIZE-3:0] index_reg;
    logic [3:0]              we_reg;
    logic [31:0]             wdata_reg;
    logic [3:0]              wait_cnt_reg;
    logic                    valid_reg;
    logic                    error_reg;
    logic [31:0]             ram_q_reg;

    logic [31:0]             mem [MEM_WORDS];
    logic [31:0]             index_ext;
    logic [MEM_AW-1:0]       mem_addr;
    logic                    in_range;
    logic                    accept;
    logic                    do_access;
    logic                    unused_addr_bits;

    assign unused_addr_bits = ^bus.address[1:0];
    assign index_ext        = 32'(index_reg);
    assign in_range         = index_ext < 32'(MEM_WORDS);
    assign mem_addr         = index_ext[MEM_AW-1:0];
    assign accept           = (state_reg == ST_IDLE) && bus.strobe;
    // An ACCESS edge that coincides with reset is aborted: no array write.
    assign do_access        = (state_reg == ST_ACCESS) && reset;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:   if (bus.strobe) state_next = (WAIT_STATES > 0) ? ST_WAIT : ST_ACCESS;
            ST_WAIT:   if (wait_cnt_reg <= 4'd1) state_next = ST_ACCESS;
            ST_ACCESS: state_next = ST_RESP;
            ST_RESP:   state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            index_reg    <= '0;
            we_reg       <= '0;
            wdata_reg    <= '0;
            wait_cnt_reg <= '0;
        end else if (accept) begin
            index_reg    <= bus.address[ADDRESS_SIZE-1:2];
            we_reg       <= bus.writeEnable;
            wdata_reg    <= bus.dataWrite;
            wait_cnt_reg <= WAIT_INIT;
        end else if (state_reg == ST_WAIT) begin
            wait_cnt_reg <= wait_cnt_reg - 4'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            valid_reg <= 1'b0;
            error_reg <= 1'b0;
        end else if (state_reg == ST_ACCESS) begin
            valid_reg <= 1'b1;
            error_reg <= !in_range;
        end
    end

    // Write-first byte-lane RAM; ram_q_reg holds the last in-range result between accesses.
    always_ff @(posedge clock) begin
        if (do_access && in_range) begin
            for (int i = 0; i < 4; i++) begin
                if (we_reg[i]) begin
                    mem[mem_addr][8*i +: 8] <= wdata_reg[8*i +: 8];
                    ram_q_reg[8*i +: 8]     <= wdata_reg[8*i +: 8];
                end else begin
                    ram_q_reg[8*i +: 8]     <= mem[mem_addr][8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        bus.ready    = (state_reg == ST_RESP);
        bus.error    = valid_reg && error_reg;
        bus.dataRead = (valid_reg && !error_reg) ? ram_q_reg : 32'h0;
    end
endmodule
